// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus definitions: register addresses, bus direction
// encodings and the sprite-DMA state type.
package nes_bus_pkg;

  // CPU-side register that starts a sprite DMA transfer
  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  // PPU OAMDATA register, destination of every DMA write
  localparam logic [15:0] OAMDATA_ADDR  = 16'h2004;

  // Bus direction encodings (read/~write)
  localparam logic        RW_READ       = 1'b1;
  localparam logic        RW_WRITE      = 1'b0;

  // Number of bytes moved by one transfer, minus one (last index)
  localparam logic [7:0]  DMA_LAST_IDX  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_e;

  // Source address of byte idx within a 256-byte page. The index never
  // carries into the page, so page $FF stays inside $FF00-$FFFF.
  function automatic logic [15:0] page_addr(input logic [7:0] page,
                                            input logic [7:0] idx);
    page_addr = {page, idx};
  endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine: a CPU write to the trigger register halts the CPU and
// copies one 256-byte page into PPU OAMDATA as alternating read/write
// bus cycles. All outputs are registers loaded from next-state values, so
// there is no combinational path from any input to any output.
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDRESS = DMA_REG_ADDR,
  parameter logic [15:0] OAMDATA_ADDRESS = OAMDATA_ADDR
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  input  logic        i_cpu_rw,
  input  logic [7:0]  i_bus_data,
  output logic        o_cpu_halt,
  output logic        o_busy,
  output logic        o_bus_en,
  output logic [15:0] o_bus_address,
  output logic [7:0]  o_bus_data,
  output logic        o_bus_rw
);

  // FSM and datapath state
  dma_state_e  state_q,  state_d;
  logic [7:0]  page_q,   page_d;
  logic [7:0]  index_q,  index_d;
  logic [7:0]  latch_q,  latch_d;
  logic        parity_q, parity_d;

  // Registered outputs and their next values
  logic        busy_q,   busy_d;
  logic        bus_en_q, bus_en_d;
  logic [15:0] addr_q,   addr_d;
  logic [7:0]  data_q,   data_d;
  logic        rw_q,     rw_d;

  logic        trigger_s;

  // CPU write to the trigger register (only acted on while idle)
  assign trigger_s = (i_cpu_rw == RW_WRITE) && (i_cpu_address == DMA_REG_ADDRESS);

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      latch_q  <= 8'h00;
      parity_q <= 1'b0;
      busy_q   <= 1'b0;
      bus_en_q <= 1'b0;
      addr_q   <= 16'h0000;
      data_q   <= 8'h00;
      rw_q     <= RW_READ;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      index_q  <= index_d;
      latch_q  <= latch_d;
      parity_q <= parity_d;
      busy_q   <= busy_d;
      bus_en_q <= bus_en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rw_q     <= rw_d;
    end
  end

  // Next-state logic: trigger capture, read/write alternation, byte counter
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    index_d  = index_q;
    latch_d  = latch_q;
    // Free-running phase bit; reads are always placed on its even phase
    parity_d = ~parity_q;

    case (state_q)
      IDLE: begin
        if (trigger_s) begin
          page_d  = i_cpu_data;
          index_d = 8'h00;
          state_d = HALT;
        end else begin
          state_d = IDLE;
        end
      end

      HALT: begin
        // parity_q==1 now means parity will be 0 in the next cycle
        if (parity_q == 1'b1) begin
          state_d = READ;
        end else begin
          state_d = ALIGN;
        end
      end

      ALIGN: begin
        state_d = READ;
      end

      READ: begin
        // Zero-wait-state bus: data is valid at the edge ending READ
        latch_d = i_bus_data;
        state_d = WRITE;
      end

      WRITE: begin
        if (index_q == DMA_LAST_IDX) begin
          state_d = IDLE;
        end else begin
          index_d = index_q + 8'd1;
          state_d = READ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe
  always_comb begin
    busy_d   = 1'b0;
    bus_en_d = 1'b0;
    addr_d   = 16'h0000;
    data_d   = 8'h00;
    rw_d     = RW_READ;

    case (state_d)
      IDLE: begin
        busy_d = 1'b0;
      end

      HALT, ALIGN: begin
        busy_d = 1'b1;
      end

      READ: begin
        busy_d   = 1'b1;
        bus_en_d = 1'b1;
        addr_d   = page_addr(page_d, index_d);
        rw_d     = RW_READ;
      end

      WRITE: begin
        busy_d   = 1'b1;
        bus_en_d = 1'b1;
        addr_d   = OAMDATA_ADDRESS;
        data_d   = latch_d;
        rw_d     = RW_WRITE;
      end

      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign o_busy        = busy_q;
  assign o_cpu_halt    = busy_q;
  assign o_bus_en      = bus_en_q;
  assign o_bus_address = addr_q;
  assign o_bus_data    = data_q;
  assign o_bus_rw      = rw_q;

endmodule
